// File: rtl/load_store_unit_if.sv
// Bus interface for load_store_unit: core-side request/response signals and
// the word-wide data-memory port. The slave modport is the LSU view; the
// master modport is the view of the core plus memory environment.
interface load_store_unit_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req;
   logic          we;
   logic [2:0]    funct3;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ready;
   logic          done;
   logic          err;
   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_address;
   logic          mem_read;
   logic          mem_write;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  req, we, funct3, addr, wdata, mem_rdata,
      output ready, done, err, rdata, mem_address, mem_read, mem_write, mem_wdata
   );

   modport master (
      output req, we, funct3, addr, wdata, mem_rdata,
      input  ready, done, err, rdata, mem_address, mem_read, mem_write, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store initiator for a word-wide,
// byte-addressed data memory with one-cycle registered read data.
// Handles lane selection, sign/zero extension and read-modify-write for
// sub-word stores.
// Optional feature macro: LSU_ALIGN_CHECK_EN -- when defined, misaligned
// halfword/word accesses are rejected with err instead of being performed.
module load_store_unit #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic [2:0]    r_state;
   logic          r_we;
   logic [2:0]    r_funct3;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_rdata;
   logic [DW-1:0] r_mem_wdata;

   logic          w_bad_code;
   logic          w_misalign;
   logic          w_reject;

   // Select the addressed byte/half of a read word and extend it to 32 bits.
   function automatic logic [31:0] f_load_extend(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  res = {{24{b[7]}}, b};
         3'b100:  res = {24'h000000, b};
         3'b001:  res = {{16{h[15]}}, h};
         3'b101:  res = {16'h0000, h};
         default: res = word;
      endcase
      return res;
   endfunction

   // Merge the low byte/half of the store data into the old memory word.
   function automatic logic [31:0] f_store_merge(input logic [31:0] old,
                                                 input logic [31:0] nw,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
      logic [31:0] res;
      res = old;
      case (f3[1:0])
         2'b00: res[{lane, 3'b000} +: 8] = nw[7:0];
         2'b01: begin
            if (lane[1]) res[31:16] = nw[15:0];
            else         res[15:0]  = nw[15:0];
         end
         default: res = nw;
      endcase
      return res;
   endfunction

   // Classify the incoming request: illegal width code or (optionally) misaligned.
   always_comb begin
      w_bad_code = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11) ||
                   (bus.we && bus.funct3[2]);
      w_misalign = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      if ((bus.funct3[1:0] == 2'b01) && bus.addr[0])
         w_misalign = 1'b1;
      if ((bus.funct3 == 3'b010) && (bus.addr[1:0] != 2'b00))
         w_misalign = 1'b1;
`endif
      w_reject = w_bad_code || w_misalign;
   end

   // Request FSM: capture on accept, read, merge/extend, write, complete.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr      <= '0;
         r_rdata     <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req) begin
                  r_we        <= bus.we;
                  r_funct3    <= bus.funct3;
                  r_addr      <= bus.addr;
                  r_mem_wdata <= bus.wdata;
                  if (w_reject)
                     r_state <= S_ERR;
                  else if (bus.we && (bus.funct3 == 3'b010))
                     r_state <= S_WR;
                  else
                     r_state <= S_RD;
               end
            end
            S_RD: r_state <= S_WAIT;
            S_WAIT: begin
               if (r_we) begin
                  // r_mem_wdata still holds the captured store data here
                  r_mem_wdata <= f_store_merge(bus.mem_rdata, r_mem_wdata,
                                               r_funct3, r_addr[1:0]);
                  r_state     <= S_WR;
               end else begin
                  r_rdata <= f_load_extend(bus.mem_rdata, r_funct3, r_addr[1:0]);
                  r_state <= S_DONE;
               end
            end
            S_WR:    r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            S_ERR:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ready       = (r_state == S_IDLE);
   assign bus.done        = (r_state == S_DONE) || (r_state == S_ERR);
   assign bus.err         = (r_state == S_ERR);
   assign bus.rdata       = r_rdata;
   assign bus.mem_address = {r_addr[AW-1:2], 2'b00};
   assign bus.mem_read    = (r_state == S_RD);
   assign bus.mem_write   = (r_state == S_WR);
   assign bus.mem_wdata   = r_mem_wdata;

endmodule
